// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//   Bundles the decode-side control inputs and the fetch-side outputs of the
//   program-counter sequencer.
//   master : decode/execute side; drives transfer requests, observes pc state.
//   slave  : the sequencer itself.
// Signals
//   advance        current instruction retires this cycle (0 = stall)
//   branch_taken   conditional branch with its condition true
//   branch_offset  signed word offset from imm[15:0]
//   jump           J/JAL in the current instruction
//   jump_target    instr_index[25:0]
//   jump_reg       JR/JALR in the current instruction
//   jump_reg_addr  rs value for JR/JALR
//   pc             address of the current instruction
//   link_addr      pc + 8
//   in_delay_slot  current instruction sits in a branch delay slot
//   active         CPU running (0 once halted)
//   address_error  sticky flag for a misaligned JR/JALR target
interface pc_sequencer_if;
  logic        advance;
  logic        branch_taken;
  logic [15:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jump_reg;
  logic [31:0] jump_reg_addr;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        in_delay_slot;
  logic        active;
  logic        address_error;

  modport master (
    output advance, branch_taken, branch_offset, jump, jump_target,
           jump_reg, jump_reg_addr,
    input  pc, link_addr, in_delay_slot, active, address_error
  );

  modport slave (
    input  advance, branch_taken, branch_offset, jump, jump_target,
           jump_reg, jump_reg_addr,
    output pc, link_addr, in_delay_slot, active, address_error
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Generates the fetch PC with a one-instruction branch delay slot. A control
//   transfer requested by the current instruction is latched as a pending
//   target; the next instruction (delay slot) executes at pc+4, after which
//   the pending target is loaded. A transfer to address 0 or a misaligned
//   JR/JALR target halts the sequencer until reset.
// Ports
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    pc_sequencer_if.slave (controls in, pc/link/status out)
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DELAY = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] pending_reg, pending_next;
  logic        addr_err_reg, addr_err_next;

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_abs_target;

  assign pc_plus4        = pc_reg + 32'd4;
  // Word offset: sign-extend to 30 bits, then shift left by two.
  assign branch_target   = pc_plus4 + {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
  // J/JAL stay within the 256 MB region of the delay-slot instruction.
  assign jump_abs_target = {pc_plus4[31:28], bus.jump_target, 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_RUN;
      pc_reg       <= RESET_VECTOR;
      pending_reg  <= 32'd0;
      addr_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      pending_reg  <= pending_next;
      addr_err_reg <= addr_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    pending_next  = pending_reg;
    addr_err_next = addr_err_reg;

    case (state_reg)
      ST_RUN: begin
        if (bus.advance) begin
          pc_next = pc_plus4;
          // Priority: jump_reg > jump > branch_taken.
          if (bus.jump_reg) begin
            pending_next = bus.jump_reg_addr;
            if (bus.jump_reg_addr[1:0] != 2'b00) begin
              addr_err_next = 1'b1;
            end
            state_next = ST_DELAY;
          end else if (bus.jump) begin
            pending_next = jump_abs_target;
            state_next   = ST_DELAY;
          end else if (bus.branch_taken) begin
            pending_next = branch_target;
            state_next   = ST_DELAY;
          end
        end
      end

      ST_DELAY: begin
        // Requests from the delay-slot instruction are ignored: no nesting.
        if (bus.advance) begin
          pc_next = pending_reg;
          if ((pending_reg == 32'd0) || addr_err_reg) begin
            state_next = ST_HALT;
          end else begin
            state_next = ST_RUN;
          end
        end
      end

      ST_HALT: begin
        // Frozen until reset.
      end

      default: begin
        state_next = ST_HALT;
      end
    endcase
  end

  assign bus.pc            = pc_reg;
  assign bus.link_addr     = pc_reg + 32'd8;
  assign bus.in_delay_slot = (state_reg == ST_DELAY);
  assign bus.active        = (state_reg != ST_HALT);
  assign bus.address_error = addr_err_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_VECTOR(32'hBFC00000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, observed);
    end
  endtask

  // One clock edge; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_requests();
    bus.branch_taken  = 1'b0;
    bus.branch_offset = 16'h0000;
    bus.jump          = 1'b0;
    bus.jump_target   = 26'h0;
    bus.jump_reg      = 1'b0;
    bus.jump_reg_addr = 32'h0;
  endtask

  task automatic do_reset();
    clear_requests();
    bus.advance = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    bus.advance  = 1'b0;
    clear_requests();
    step();

    // 1: reset state and straight-line sequencing
    do_reset();
    check("rst_pc", bus.pc, 32'hBFC00000);
    check("rst_active", {31'd0, bus.active}, 32'd1);
    check("rst_delay", {31'd0, bus.in_delay_slot}, 32'd0);
    check("rst_aerr", {31'd0, bus.address_error}, 32'd0);
    check("rst_link", bus.link_addr, 32'hBFC00008);
    step(); check("seq_pc1", bus.pc, 32'hBFC00004);
    step(); check("seq_pc2", bus.pc, 32'hBFC00008);
    step(); check("seq_pc3", bus.pc, 32'hBFC0000C);
    check("seq_active", {31'd0, bus.active}, 32'd1);

    // 2: backward branch from 0xBFC00010
    step(); check("br_start", bus.pc, 32'hBFC00010);
    bus.branch_taken = 1'b1; bus.branch_offset = 16'hFFFC;
    step();
    check("br_slot_pc", bus.pc, 32'hBFC00014);
    check("br_slot_flag", {31'd0, bus.in_delay_slot}, 32'd1);
    clear_requests();
    step();
    check("br_target", bus.pc, 32'hBFC00004);
    check("br_after_flag", {31'd0, bus.in_delay_slot}, 32'd0);

    // Stall in RUN with a pending request: nothing changes
    bus.advance = 1'b0; bus.jump = 1'b1; bus.jump_target = 26'h1;
    step(); step();
    check("stall_run_pc", bus.pc, 32'hBFC00004);
    check("stall_run_flag", {31'd0, bus.in_delay_slot}, 32'd0);
    clear_requests(); bus.advance = 1'b1;

    // 3: J from reset vector
    do_reset();
    bus.jump = 1'b1; bus.jump_target = 26'h40;
    check("j_link", bus.link_addr, 32'hBFC00008);
    step();
    check("j_slot_pc", bus.pc, 32'hBFC00004);
    clear_requests();
    step();
    check("j_target", bus.pc, 32'hB0000100);
    check("j_active", {31'd0, bus.active}, 32'd1);

    // 4: JR to 0 halts after the delay slot and stays halted
    do_reset();
    bus.jump_reg = 1'b1; bus.jump_reg_addr = 32'h0;
    step();
    check("halt_slot_pc", bus.pc, 32'hBFC00004);
    clear_requests();
    step();
    check("halt_pc", bus.pc, 32'h00000000);
    check("halt_active", {31'd0, bus.active}, 32'd0);
    bus.jump_reg = 1'b1; bus.jump_reg_addr = 32'h100;
    bus.jump = 1'b1; bus.branch_taken = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("halt_hold_pc", bus.pc, 32'h00000000);
    check("halt_hold_active", {31'd0, bus.active}, 32'd0);
    check("halt_hold_flag", {31'd0, bus.in_delay_slot}, 32'd0);
    clear_requests();

    // link_addr and pc wrap at the top of the address space
    do_reset();
    bus.jump_reg = 1'b1; bus.jump_reg_addr = 32'hFFFFFFFC;
    step(); clear_requests(); step();
    check("wrap_pc", bus.pc, 32'hFFFFFFFC);
    check("wrap_link", bus.link_addr, 32'h00000004);
    step();
    check("wrap_pc_next", bus.pc, 32'h00000000);
    check("wrap_active", {31'd0, bus.active}, 32'd1);

    // 5: misaligned JR target
    do_reset();
    bus.jump_reg = 1'b1; bus.jump_reg_addr = 32'hBFC00102;
    step();
    check("aerr_flag", {31'd0, bus.address_error}, 32'd1);
    check("aerr_slot_pc", bus.pc, 32'hBFC00004);
    check("aerr_slot_active", {31'd0, bus.active}, 32'd1);
    clear_requests();
    step();
    check("aerr_halt_pc", bus.pc, 32'hBFC00102);
    check("aerr_halt_active", {31'd0, bus.active}, 32'd0);
    check("aerr_sticky", {31'd0, bus.address_error}, 32'd1);
    do_reset();
    check("aerr_cleared", {31'd0, bus.address_error}, 32'd0);

    // 6: stall in DELAY, ignored nested branch, reset mid-DELAY
    bus.branch_taken = 1'b1; bus.branch_offset = 16'h0010;
    step();
    clear_requests();
    bus.advance = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("dstall_pc", bus.pc, 32'hBFC00004);
    check("dstall_flag", {31'd0, bus.in_delay_slot}, 32'd1);
    bus.advance = 1'b1; bus.branch_taken = 1'b1; bus.branch_offset = 16'h0100;
    step();
    check("nest_target", bus.pc, 32'hBFC00044);
    check("nest_flag", {31'd0, bus.in_delay_slot}, 32'd0);
    clear_requests();
    step();
    check("nest_after", bus.pc, 32'hBFC00048);
    check("nest_after_flag", {31'd0, bus.in_delay_slot}, 32'd0);

    bus.jump = 1'b1; bus.jump_target = 26'h40;
    step();
    clear_requests();
    check("mid_slot_flag", {31'd0, bus.in_delay_slot}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_pc", bus.pc, 32'hBFC00000);
    check("mid_rst_flag", {31'd0, bus.in_delay_slot}, 32'd0);
    check("mid_rst_active", {31'd0, bus.active}, 32'd1);
    step(); check("mid_rst_pc1", bus.pc, 32'hBFC00004);
    step(); check("mid_rst_pc2", bus.pc, 32'hBFC00008);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
